neuron_sequencer: RTL and testbench
===================================

# neuron_sequencer

Control stage directly upstream of the fixed-point MAC core. It runs one neuron evaluation per `start`:
- fetches the bias and `N_INPUTS` weight/input pairs from synchronous memories;
- drives the MAC core's `init`/`en`/`din`/`mem_in` ports with correct cycle alignment;
- captures the accumulator and optionally applies ReLU;
- presents the result on a valid/ready output port.

One instance sits between the weight/input buffers and one MAC core per neuron lane.

## Interface
Parameters:
- `INT_BITS`, default 5: integer bits of the Q format. Must match the MAC core.
- `FRC_BITS`, default 7: fractional bits. Data width is W = `INT_BITS`+`FRC_BITS` = 12.
- `N_INPUTS`, default 16: inputs per neuron. Must be ≥1.
- `AW`, default `$clog2(N_INPUTS+1)`: address width.

Ports (all synchronous to `clk`):
- `clk`  in  1: clock. Everything is on the rising edge.
- `rst`  in  1: reset. Synchronous and active-high.
- `start`  in  1: start one neuron evaluation. Sampled only in IDLE.
- `busy`  out  1: high in every state except IDLE.
- `wgt_addr`  out  AW: weight memory address. Address 0 is the bias; addresses 1..N are the weights.
- `wgt_data`  in  W: weight memory read data. Read latency is 1 cycle.
- `x_addr`  out  AW: input buffer address, 0..N-1.
- `x_data`  in  W: input buffer read data. Read latency is 1 cycle.
- `mac_init`  out  1: drives the MAC core `init`.
- `mac_en`  out  1: drives the MAC core `en`.
- `mac_din`  out  W: drives the MAC core `din`.
- `mac_mem_in`  out  W: drives the MAC core `mem_in`.
- `mac_out`  in  W: MAC core accumulator output.
- `result`  out  W: neuron result in two's-complement Q format.
- `result_valid`  out  1: `result` is valid.
- `result_ready`  in  1: downstream accepts `result`.

## Operation
State machine states: IDLE, BIAS_RD, BIAS_LD, ACC, CAPT, OUT. Index counter `k` has width AW.
- **IDLE:** waits for `start`=1, then goes to BIAS_RD.
- **BIAS_RD:** drives `wgt_addr`=0. Goes to BIAS_LD.
- **BIAS_LD:**
  - `mac_init`=1 and `mac_mem_in`=`wgt_data` (the bias).
  - Issues `wgt_addr`=1 and `x_addr`=0. Sets `k`=0.
  - Goes to ACC.
- **ACC:**
  - `mac_en`=1, `mac_din`=`x_data`, `mac_mem_in`=`wgt_data`. These are the pair for index `k`.
  - If `k`<N-1, issues `wgt_addr`=k+2 and `x_addr`=k+1.
  - `k` increments. After the cycle with `k`=N-1, goes to CAPT.
- **CAPT:** the accumulator now holds bias + Σ. Loads `result` from the activation of `mac_out`. Goes to OUT.
- **OUT:** `result_valid`=1. When `result_ready`=1, the handshake completes and the block returns to IDLE.

Output rules:
- When `mac_init`=`mac_en`=0, `mac_din` and `mac_mem_in` are driven to 0.
- `mac_init` and `mac_en` are never high in the same cycle.
- `wgt_addr` and `x_addr` are 0 when not issuing.
- Arithmetic is done entirely in the MAC core (truncating Q-format multiply, wrapping add). This block never modifies data except for activation.

Boundary conditions:
- `start` outside IDLE is ignored. It is not queued.
- In OUT with `result_ready`=0: `result` and `result_valid` are held unchanged indefinitely.
- With `result_ready` held high, the handshake completes in the first OUT cycle. The next `start` is accepted no earlier than the following cycle, which is IDLE.
- `rst`=1 in any state:
  - Next state is IDLE and `k`=0.
  - `result`=0 and all outputs are 0 from the next cycle.
  - The MAC core accumulator is left untouched; the next BIAS_LD reinitialises it.
- N_INPUTS=1: ACC lasts exactly one cycle.

## Timing
- Reset values: `busy`=0, `result_valid`=0, `result`=0, `mac_init`=0, `mac_en`=0, `mac_din`=0, `mac_mem_in`=0, `wgt_addr`=0, `x_addr`=0.
- Cycle count:
  - `start` sampled at cycle 0.
  - BIAS_RD at cycle 1, BIAS_LD at cycle 2.
  - ACC at cycles 3..N+2, CAPT at cycle N+3.
  - `result_valid` first high at cycle N+4.
- Throughput is one neuron per N+5 cycles with `result_ready` tied high.
- `mac_init` is high for exactly 1 cycle per run. `mac_en` is high for exactly N consecutive cycles.
- All outputs are registered or decoded from state only. There is no combinational path from `result_ready` or `start` to any output.

## Configuration
- Macro `NEURON_SEQ_RELU_EN`.
- Defined: `result` = 0 when `mac_out[W-1]`=1, otherwise `mac_out`.
- Undefined: `result` = `mac_out` unchanged (linear activation).
- Timing and handshake are identical in both builds.

## Test plan
Default Q5.7 and N=4 in all scenarios; the bench models the MAC core.
- **Basic run:** bias 0x080 (1.0), weights 0x080 (1.0), inputs 0x040 (0.5) → `result`=0x180 (3.0) at cycle 8. Check `mac_init` for 1 cycle and `mac_en` for 4 cycles.
- **Negative sum:** bias 0xF00 (−2.0), all weights 0. With the macro defined → `result`=0x000. Without it → 0xF00.
- **Backpressure:** hold `result_ready`=0 for 5 cycles after `result_valid` → `result` is stable, `busy`=1, no new addresses issued. Raise `result_ready` → IDLE next cycle.
- **Busy start:** pulse `start` during ACC → ignored. Exactly one result is produced, and the address sequences are 0,1,2,3,4 (`wgt_addr`) and 0,1,2,3 (`x_addr`).
- **Reset mid-run:** assert `rst` on the 2nd ACC cycle → all outputs are 0 and the block is in IDLE next cycle. A fresh `start` then reproduces the basic-run result 0x180.
- **Back-to-back:** `result_ready`=1 with `start` asserted the cycle after the handshake → second result valid 9 cycles later with the correct value.

Source files
------------

// File: rtl/neuron_sequencer.sv
// neuron_sequencer: drives one fixed-point MAC core through a single
// neuron evaluation (bias load, N multiply-accumulates, capture, output).
// Params: INT_BITS, FRC_BITS (Q format), N_INPUTS, AW (address width).
// Ports : clk, rst (sync, active-high), start, busy,
//         wgt_addr/wgt_data (bias at 0, weights 1..N, 1-cycle latency),
//         x_addr/x_data (inputs 0..N-1, 1-cycle latency),
//         mac_init/mac_en/mac_din/mac_mem_in/mac_out (MAC core),
//         result/result_valid/result_ready (valid/ready output).
// Build : define NEURON_SEQ_RELU_EN for ReLU activation, else linear.
module neuron_sequencer #(
  parameter int INT_BITS = 5,
  parameter int FRC_BITS = 7,
  parameter int N_INPUTS = 16,
  parameter int AW       = $clog2(N_INPUTS + 1),
  localparam int W       = INT_BITS + FRC_BITS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic [AW-1:0] wgt_addr,
  input  logic [W-1:0]  wgt_data,
  output logic [AW-1:0] x_addr,
  input  logic [W-1:0]  x_data,
  output logic          mac_init,
  output logic          mac_en,
  output logic [W-1:0]  mac_din,
  output logic [W-1:0]  mac_mem_in,
  input  logic [W-1:0]  mac_out,
  output logic [W-1:0]  result,
  output logic          result_valid,
  input  logic          result_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS_RD,
    S_BIAS_LD,
    S_ACC,
    S_CAPT,
    S_OUT
  } state_t;

  localparam logic [AW-1:0] K_LAST = AW'(N_INPUTS - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [W-1:0]  result_q, result_d;
  logic [W-1:0]  act;

  // Activation of the accumulator as seen in CAPT.
  always_comb begin
`ifdef NEURON_SEQ_RELU_EN
    act = mac_out[W-1] ? '0 : mac_out;
`else
    act = mac_out;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      result_q <= result_d;
    end
  end

  // Memory reads are issued one cycle ahead of use: the address driven
  // in cycle t returns data in cycle t+1, where it feeds the MAC.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    result_d     = result_q;
    busy         = 1'b1;
    mac_init     = 1'b0;
    mac_en       = 1'b0;
    mac_din      = '0;
    mac_mem_in   = '0;
    wgt_addr     = '0;
    x_addr       = '0;
    result_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_BIAS_RD;
      end
      S_BIAS_RD: begin
        state_d = S_BIAS_LD;
      end
      S_BIAS_LD: begin
        mac_init   = 1'b1;
        mac_mem_in = wgt_data;
        wgt_addr   = AW'(1);
        k_d        = '0;
        state_d    = S_ACC;
      end
      S_ACC: begin
        mac_en     = 1'b1;
        mac_din    = x_data;
        mac_mem_in = wgt_data;
        k_d        = k_q + AW'(1);
        if (k_q == K_LAST) begin
          state_d = S_CAPT;
        end else begin
          wgt_addr = k_q + AW'(2);
          x_addr   = k_q + AW'(1);
        end
      end
      S_CAPT: begin
        result_d = act;
        state_d  = S_OUT;
      end
      S_OUT: begin
        result_valid = 1'b1;
        if (result_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign result = result_q;

endmodule

// File: tb/tb_neuron_sequencer.sv
// tb_neuron_sequencer: directed + randomized bench for neuron_sequencer
// with behavioural memories and MAC core, Q5.7, N=4.
module tb_neuron_sequencer;

  localparam int N  = 4;
  localparam int IB = 5;
  localparam int FB = 7;
  localparam int W  = IB + FB;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic [AW-1:0] wgt_addr;
  logic [W-1:0]  wgt_data;
  logic [AW-1:0] x_addr;
  logic [W-1:0]  x_data;
  logic          mac_init;
  logic          mac_en;
  logic [W-1:0]  mac_din;
  logic [W-1:0]  mac_mem_in;
  logic [W-1:0]  mac_out;
  logic [W-1:0]  result;
  logic          result_valid;
  logic          result_ready;

  logic [W-1:0] wmem [0:7];
  logic [W-1:0] xmem [0:7];
  logic [W-1:0] acc;

  int cmp  = 0;
  int mism = 0;

  always #5 clk = ~clk;

  neuron_sequencer #(
    .INT_BITS(IB),
    .FRC_BITS(FB),
    .N_INPUTS(N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .wgt_addr    (wgt_addr),
    .wgt_data    (wgt_data),
    .x_addr      (x_addr),
    .x_data      (x_data),
    .mac_init    (mac_init),
    .mac_en      (mac_en),
    .mac_din     (mac_din),
    .mac_mem_in  (mac_mem_in),
    .mac_out     (mac_out),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready)
  );

  function automatic logic [W-1:0] mulq(input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    p = p >>> FB;
    return p[W-1:0];
  endfunction

  // Synchronous memories and MAC core.
  always @(posedge clk) begin
    wgt_data <= wmem[wgt_addr];
    x_data   <= xmem[x_addr];
    if (mac_init)    acc <= mac_mem_in;
    else if (mac_en) acc <= acc + mulq(mac_din, mac_mem_in);
  end

  assign mac_out = acc;

  // Neuron value: bias + sum of truncated products, wrapped to W bits.
  function automatic logic [W-1:0] ref_neuron();
    int s;
    int p;
    logic [W-1:0] r;
    s = int'($signed(wmem[0]));
    for (int i = 0; i < N; i++) begin
      p = int'($signed(wmem[i+1])) * int'($signed(xmem[i]));
      s = s + (p >>> FB);
    end
    r = s[W-1:0];
`ifdef NEURON_SEQ_RELU_EN
    if (r[W-1]) r = '0;
`endif
    return r;
  endfunction

  function automatic logic [63:0] obsv();
    return {30'b0, busy, mac_init, mac_en, result_valid,
            wgt_addr, x_addr, mac_din, mac_mem_in};
  endfunction

  // Expected outputs in cycle c after start was sampled (c=1: BIAS_RD).
  function automatic logic [63:0] texp(input int c);
    logic          b;
    logic          i;
    logic          e;
    logic          v;
    logic [AW-1:0] wa;
    logic [AW-1:0] xa;
    logic [W-1:0]  d;
    logic [W-1:0]  m;
    int            k;
    b = 1'b1; i = 1'b0; e = 1'b0; v = 1'b0;
    wa = '0; xa = '0; d = '0; m = '0;
    if (c == 2) begin
      i  = 1'b1;
      wa = AW'(1);
      m  = wmem[0];
    end else if (c >= 3 && c <= N + 2) begin
      k = c - 3;
      e = 1'b1;
      d = xmem[k];
      m = wmem[k+1];
      if (k < N - 1) begin
        wa = AW'(k + 2);
        xa = AW'(k + 1);
      end
    end else if (c >= N + 4) begin
      v = 1'b1;
    end
    return {30'b0, b, i, e, v, wa, xa, d, m};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One evaluation; caller is at a negedge in IDLE. ready is held low
  // for the first `hold` OUT cycles; start is re-pulsed at cycle pulse_at.
  task automatic run(input int hold, input int pulse_at);
    logic [W-1:0] r;
    r = ref_neuron();
    result_ready = (hold == 0);
    start = 1'b1;
    for (int c = 1; c <= N + 4 + hold; c++) begin
      @(negedge clk);
      start = (c == pulse_at);
      check("timeline", obsv(), texp(c));
      if (c >= N + 4) check("result", {52'b0, result}, {52'b0, r});
      if (c == N + 4 + hold) result_ready = 1'b1;
    end
    start = 1'b0;
    @(negedge clk);
    check("idle_after", {62'b0, busy, result_valid}, 64'd0);
  endtask

  task automatic fill_basic();
    wmem[0] = 12'h080;
    for (int i = 0; i < N; i++) begin
      wmem[i+1] = 12'h080;
      xmem[i]   = 12'h040;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 8; i++) begin
      wmem[i] = W'($urandom);
      xmem[i] = W'($urandom);
    end
  endtask

  logic [W-1:0] neg_exp;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    result_ready = 1'b0;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      wmem[i] = '0;
      xmem[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("reset_outs", obsv(), 64'd0);
    check("reset_result", {52'b0, result}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic run.
    fill_basic();
    run(0, 0);
    check("basic_value", {52'b0, result}, 64'h180);

    // Negative sum.
    fill_random();
    wmem[0] = 12'hF00;
    for (int i = 1; i <= N; i++) wmem[i] = '0;
`ifdef NEURON_SEQ_RELU_EN
    neg_exp = 12'h000;
`else
    neg_exp = 12'hF00;
`endif
    run(0, 0);
    check("neg_value", {52'b0, result}, {52'b0, neg_exp});

    // Backpressure.
    fill_random();
    run(5, 0);

    // Start pulsed during ACC is not queued.
    fill_basic();
    run(0, 4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_queue", {63'b0, busy}, 64'd0);
    end

    // Reset on the 2nd ACC cycle.
    fill_random();
    start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 4) rst = 1'b1;
    end
    @(negedge clk);
    check("midrst_outs", obsv(), 64'd0);
    check("midrst_result", {52'b0, result}, 64'd0);
    rst = 1'b0;
    fill_basic();
    run(0, 0);
    check("post_rst_value", {52'b0, result}, 64'h180);

    // Back-to-back.
    fill_random();
    run(0, 0);
    fill_random();
    run(0, 0);

    // Randomized runs.
    for (int t = 0; t < 6; t++) begin
      fill_random();
      run(int'($urandom_range(0, 3)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end

endmodule
